// File: rtl/izhikevich_step_sequencer_if.sv
// Request/response bundle for the Izhikevich neuron step sequencer.
// The master drives the start request and operands; the slave returns the status and results.
interface izhikevich_step_sequencer_if #(
  parameter int N = 32
) ();
  logic         start;
  logic [N-1:0] a, b, c, d;
  logic [N-1:0] v_in, w_in, i_in, step;
  logic         busy;
  logic         done;
  logic [N-1:0] v_out, w_out;
  logic         spike;

  modport master (
    output start, a, b, c, d, v_in, w_in, i_in, step,
    input  busy, done, v_out, w_out, spike
  );

  modport slave (
    input  start, a, b, c, d, v_in, w_in, i_in, step,
    output busy, done, v_out, w_out, spike
  );
endinterface

// File: rtl/izhikevich_step_sequencer.sv
// Sequencer for one Izhikevich neuron update.
// A single shared Q-format multiplier produces one product per cycle in states M1..M7.
// UPD applies the threshold test, and DONE pulses done for one cycle.
module izhikevich_step_sequencer #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input logic                         clk,
  input logic                         rst_n,
  izhikevich_step_sequencer_if.slave  bus
);
  localparam longint ONE = 64'sd1 <<< Q;
  localparam logic [N-1:0] K04  = N'((4 * ONE + 50) / 100);
  localparam logic [N-1:0] K5   = N'(5 * ONE);
  localparam logic [N-1:0] K140 = N'(140 * ONE);
  localparam logic [N-1:0] VTH  = N'(30 * ONE);

  typedef enum logic [3:0] {
    IDLE, M1, M2, M3, M4, M5, M6, M7, UPD, DONE
  } state_t;

  state_t state_q, state_d;

  // latched operands
  logic [N-1:0] ra, rb, rc, rd, rv, rw, ri, rstep;
  // intermediates: t = b*v - w, acc holds p2/p4/p5, s = dv/dt sum
  logic [N-1:0] t, acc, dw, s, dv;
  logic [N-1:0] vo_q, wo_q;
  logic         spk_q;

  logic [N-1:0]          ma, mb, mres, vn, wn;
  logic signed [2*N-1:0] prod;

  // Operand select for the one shared multiplier.
  always_comb begin
    ma = '0;
    mb = '0;
    case (state_q)
      M1: begin ma = rb;   mb = rv;    end
      M2: begin ma = ra;   mb = t;     end
      M3: begin ma = acc;  mb = rstep; end
      M4: begin ma = rv;   mb = rv;    end
      M5: begin ma = K04;  mb = acc;   end
      M6: begin ma = K5;   mb = rv;    end
      M7: begin ma = s;    mb = rstep; end
      default: ;
    endcase
  end

  // Full-width signed product. Shifting right by Q and keeping the low N bits truncates toward -inf and wraps.
  assign prod = $signed(ma) * $signed(mb);
  assign mres = prod[Q +: N];

  assign vn = rv + dv;
  assign wn = rw + dw;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Every non-IDLE state lasts one cycle, and start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = M1;
      M1:   state_d = M2;
      M2:   state_d = M3;
      M3:   state_d = M4;
      M4:   state_d = M5;
      M5:   state_d = M6;
      M6:   state_d = M7;
      M7:   state_d = UPD;
      UPD:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath. Operands are captured on start, products are scheduled per state, and results are committed in UPD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ra, rb, rc, rd, rv, rw, ri, rstep} <= '0;
      {t, acc, dw, s, dv}                 <= '0;
      vo_q  <= '0;
      wo_q  <= '0;
      spk_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          ra <= bus.a;    rb <= bus.b;    rc <= bus.c;    rd <= bus.d;
          rv <= bus.v_in; rw <= bus.w_in; ri <= bus.i_in; rstep <= bus.step;
        end
        M1: t   <= mres - rw;
        M2: acc <= mres;
        M3: dw  <= mres;
        M4: acc <= mres;
        M5: acc <= mres;
        M6: s   <= acc + mres + K140 - rw + ri;
        M7: dv  <= mres;
        UPD: begin
          if ($signed(vn) >= $signed(VTH)) begin
            vo_q  <= rc;
            wo_q  <= wn + rd;
            spk_q <= 1'b1;
          end else begin
            vo_q  <= vn;
            wo_q  <= wn;
            spk_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.v_out = vo_q;
  assign bus.w_out = wo_q;
  assign bus.spike = spk_q;
endmodule

// File: tb/tb_izhikevich_step_sequencer.sv
// Self-checking bench for izhikevich_step_sequencer (N=32, Q=16).
// Directed vectors come from a table, random vectors are checked against an arithmetic model,
// and hand-written sequences cover busy reject, input stability and reset during an update.
module tb_izhikevich_step_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  izhikevich_step_sequencer_if #(.N(32)) bus ();
  izhikevich_step_sequencer #(.N(32), .Q(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] a, b, c, d, v, w, i, st;
    logic [31:0] ev, ew;
    logic        es;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] K04  = 32'h0000_0A3D;
  localparam logic [31:0] K5   = 32'h0005_0000;
  localparam logic [31:0] K140 = 32'h008C_0000;
  localparam logic [31:0] VTH  = 32'h001E_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Q16.16 multiply: exact product, floor-shift by 16, wrap to 32 bits.
  function automatic logic [31:0] mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    p = p >>> 16;
    return p[31:0];
  endfunction

  // Reference neuron step, written directly from the update equations.
  function automatic vec_t model(input vec_t x);
    vec_t r;
    logic [31:0] tt, dw, s, dv, vn, wn;
    r  = x;
    tt = mul(x.b, x.v) - x.w;
    dw = mul(mul(x.a, tt), x.st);
    s  = mul(K04, mul(x.v, x.v)) + mul(K5, x.v) + K140 - x.w + x.i;
    dv = mul(s, x.st);
    vn = x.v + dv;
    wn = x.w + dw;
    if ($signed(vn) >= $signed(VTH)) begin
      r.ev = x.c; r.ew = wn + x.d; r.es = 1'b1;
    end else begin
      r.ev = vn;  r.ew = wn;       r.es = 1'b0;
    end
    return r;
  endfunction

  task automatic drive(input vec_t x);
    bus.a = x.a; bus.b = x.b; bus.c = x.c; bus.d = x.d;
    bus.v_in = x.v; bus.w_in = x.w; bus.i_in = x.i; bus.step = x.st;
  endtask

  task automatic scramble();
    bus.a = $urandom; bus.b = $urandom; bus.c = $urandom; bus.d = $urandom;
    bus.v_in = $urandom; bus.w_in = $urandom; bus.i_in = $urandom; bus.step = $urandom;
  endtask

  // Runs one update. Checks that done arrives in cycle 9 with busy high until then,
  // checks the results, and checks that the outputs hold in the following idle cycle.
  task automatic run_update(input string name, input vec_t x, input bit scr);
    int dcyc;
    int bbad;
    dcyc = 0;
    bbad = 0;
    @(negedge clk);
    drive(x);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 15 && dcyc == 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (scr && k == 3) scramble();
      if (bus.busy !== 1'b1) bbad++;
      if (bus.done === 1'b1) dcyc = k;
    end
    chk({name, " latency"}, dcyc, 9);
    chk({name, " busy"}, bbad, 0);
    chk({name, " v_out"}, bus.v_out, x.ev);
    chk({name, " w_out"}, bus.w_out, x.ew);
    chk({name, " spike"}, {31'd0, bus.spike}, {31'd0, x.es});
    @(negedge clk);
    chk({name, " done pulse"}, {31'd0, bus.done}, 32'd0);
    chk({name, " idle"}, {31'd0, bus.busy}, 32'd0);
    chk({name, " hold v"}, bus.v_out, x.ev);
  endtask

  vec_t tbl[5];
  vec_t rest_v, spk_v, rv;

  initial begin
    int dn, c1, c2, bb, drained;
    bus.start = 1'b0;
    drive('{default: '0});

    // Neuron parameters a=0.02, b=0.2, c=-65, d=8.
    // rest: v=-65, w=-13, i=0, step=1
    rest_v = '{a: 32'h0000_051F, b: 32'h0000_3333, c: 32'hFFBF_0000, d: 32'h0008_0000,
               v: 32'hFFBF_0000, w: 32'hFFF3_0000, i: 32'h0, st: 32'h0001_0000,
               ev: 32'hFFBB_F8BD, ew: 32'hFFF3_0000, es: 1'b0};
    // spike: v=29, w=0, i=10, step=1
    spk_v  = '{a: 32'h0000_051F, b: 32'h0000_3333, c: 32'hFFBF_0000, d: 32'h0008_0000,
               v: 32'h001D_0000, w: 32'h0, i: 32'h000A_0000, st: 32'h0001_0000,
               ev: 32'hFFBF_0000, ew: 32'h0008_1DB3, es: 1'b1};
    tbl[0] = rest_v;
    tbl[1] = spk_v;
    // step=0 gives dv=dw=0, so vn equals v: this probes the threshold exactly.
    tbl[2] = '{a: 32'h0000_051F, b: 32'h0000_3333, c: 32'hFFBF_0000, d: 32'h0008_0000,
               v: 32'h001E_0000, w: 32'h0, i: 32'h0, st: 32'h0,
               ev: 32'hFFBF_0000, ew: 32'h0008_0000, es: 1'b1};
    tbl[3] = '{a: 32'h0000_051F, b: 32'h0000_3333, c: 32'hFFBF_0000, d: 32'h0008_0000,
               v: 32'h001D_FFFF, w: 32'h0001_0000, i: 32'h0, st: 32'h0,
               ev: 32'h001D_FFFF, ew: 32'h0001_0000, es: 1'b0};
    // negative step, far below threshold
    tbl[4] = '{a: 32'h0000_051F, b: 32'h0000_3333, c: 32'hFFBF_0000, d: 32'h0008_0000,
               v: 32'h0, w: 32'h0, i: 32'h0, st: 32'hFFFF_0000,
               ev: 32'hFF74_0000, ew: 32'h0, es: 1'b0};

    // reset state
    #12;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst v_out", bus.v_out, 32'd0);
    chk("rst w_out", bus.w_out, 32'd0);
    chk("rst spike", {31'd0, bus.spike}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 5; n++) run_update($sformatf("vec%0d", n), tbl[n], 1'b0);

    // random vectors: half unconstrained words, half in a plausible neuron range
    for (int n = 0; n < 16; n++) begin
      rv = '{default: '0};
      if (n % 2 == 0) begin
        rv.a = $urandom; rv.b = $urandom; rv.c = $urandom; rv.d = $urandom;
        rv.v = $urandom; rv.w = $urandom; rv.i = $urandom; rv.st = $urandom;
      end else begin
        rv.a = $urandom_range(32'h0000_2000); rv.b = $urandom_range(32'h0000_8000);
        rv.c = 32'hFFBF_0000;                 rv.d = $urandom_range(32'h000A_0000);
        rv.v = $urandom_range(32'h0078_0000) - 32'h0055_0000;
        rv.w = $urandom_range(32'h0028_0000) - 32'h0014_0000;
        rv.i = $urandom_range(32'h0014_0000); rv.st = $urandom_range(32'h0001_0000);
      end
      run_update($sformatf("rnd%0d", n), model(rv), 1'b0);
    end

    // inputs scrambled in cycle 3 must not disturb the latched update
    run_update("stable", spk_v, 1'b1);

    // start held for 25 cycles: requests while busy are dropped, and a new one is taken only in IDLE
    dn = 0; c1 = 0; c2 = 0; bb = 0; drained = 0;
    @(negedge clk);
    drive(rest_v);
    bus.start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dn++;
        if (dn == 1) c1 = k;
        if (dn == 2) c2 = k;
      end
      if (bus.busy !== (k % 10 != 0)) bb++;
    end
    bus.start = 1'b0;
    chk("hold dones", dn, 2);
    chk("hold done1 cycle", c1, 9);
    chk("hold done2 cycle", c2, 19);
    chk("hold busy pattern", bb, 0);
    for (int k = 0; k < 15 && drained == 0; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) drained = 1;
    end
    chk("hold drain", drained, 1);
    chk("hold result", bus.v_out, rest_v.ev);
    @(negedge clk);

    // reset in cycle 5 aborts the update; the next start runs normally
    run_update("pre-reset", spk_v, 1'b0);
    @(negedge clk);
    drive(rest_v);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort v_out", bus.v_out, 32'd0);
    chk("abort w_out", bus.w_out, 32'd0);
    chk("abort spike", {31'd0, bus.spike}, 32'd0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (bus.done === 1'b1) dn++;
    end
    chk("abort no done", dn, 0);
    run_update("post-reset", spk_v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
